// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI response codes, FSM state types and address decode for the SRAM responder.
package ysyx_23060203_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_WAIT,
        W_RESP
    } wr_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

    // True when addr falls in [base, base + 4*depth).
    function automatic logic axi_addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                          input logic [31:0] depth);
        return (addr >= base) && (((addr - base) >> 2) < depth);
    endfunction

endpackage

// File: rtl/axi_if.sv
// Single-beat AXI4 bundle; the "in" modport is the responder side.
interface axi_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport in (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rid, rlast,
        output awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/ysyx_23060203_sram_array.sv
// DEPTHx32 word array: one synchronous read port, one byte-strobed write port.
module ysyx_23060203_sram_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_en,
    input  logic             rd_hit,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Errored reads return zero; the register holds its value between captures.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_hit ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/ysyx_23060203_axi_sram.sv
// AXI4 single-beat SRAM responder with independent read and write state machines.
module ysyx_23060203_axi_sram
    import ysyx_23060203_axi_pkg::*;
#(
    parameter logic [31:0] BASE          = 32'h8000_0000,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input logic clock,
    input logic reset,
    axi_if.in   mem_r,
    axi_if.in   mem_w
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic        RD_ZERO_LAT = (READ_LATENCY == 0);

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE) >> 2);
    endfunction

    function automatic logic [1:0] req_resp(input logic [31:0] addr, input logic [7:0] len);
        if (!axi_addr_hit(addr, BASE, 32'(DEPTH))) return RESP_DECERR;
        if (len != 8'd0) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    rd_state_t        rd_state, rd_next;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_next;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_c;
    logic [1:0]       rd_resp_q, rd_resp_c, ar_resp_c;
    logic             rd_capture_c;
    logic             arready_q, rvalid_q;
    logic [1:0]       rresp_q;
    logic [3:0]       rid_q;
    logic [31:0]      rd_data;
    logic             ar_hs, r_hs;

    wr_state_t        wr_state, wr_next;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_next;
    logic [IDX_W-1:0] wr_idx_q;
    logic [1:0]       wr_resp_q;
    wbeat_t           wr_beat_q;
    logic             wr_commit_c;
    logic             awready_q, wready_q, bvalid_q;
    logic [1:0]       bresp_q;
    logic [3:0]       bid_q;
    logic             aw_hs, w_hs, b_hs;

    assign ar_hs     = mem_r.arvalid && arready_q;
    assign r_hs      = rvalid_q && mem_r.rready;
    assign aw_hs     = mem_w.awvalid && awready_q;
    assign w_hs      = mem_w.wvalid && wready_q;
    assign b_hs      = bvalid_q && mem_w.bready;
    assign ar_resp_c = req_resp(mem_r.araddr, mem_r.arlen);

    // Read next-state; zero latency captures straight from the AR handshake.
    always_comb begin
        rd_next      = rd_state;
        rd_cnt_next  = rd_cnt;
        rd_capture_c = 1'b0;
        rd_idx_c     = rd_idx_q;
        rd_resp_c    = rd_resp_q;
        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_idx_c  = word_idx(mem_r.araddr);
                    rd_resp_c = ar_resp_c;
                    if (RD_ZERO_LAT) begin
                        rd_next      = R_RESP;
                        rd_capture_c = 1'b1;
                    end else begin
                        rd_next     = R_WAIT;
                        rd_cnt_next = CNT_W'(READ_LATENCY);
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt == '0) begin
                    rd_next      = R_RESP;
                    rd_capture_c = 1'b1;
                end else begin
                    rd_cnt_next = rd_cnt - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (r_hs) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_state  <= R_IDLE;
            rd_cnt    <= '0;
            rd_idx_q  <= '0;
            rd_resp_q <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
        end else begin
            rd_state  <= rd_next;
            rd_cnt    <= rd_cnt_next;
            arready_q <= (rd_next == R_IDLE);
            rvalid_q  <= (rd_next == R_RESP);
            if (ar_hs) begin
                rd_idx_q  <= rd_idx_c;
                rd_resp_q <= ar_resp_c;
                rid_q     <= mem_r.arid;
            end
            if (rd_capture_c) rresp_q <= rd_resp_c;
        end
    end

    // Write next-state; AW and W may arrive together or in either order.
    always_comb begin
        wr_next     = wr_state;
        wr_cnt_next = wr_cnt;
        wr_commit_c = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_next     = W_WAIT;
                    wr_cnt_next = CNT_W'(WRITE_LATENCY);
                end else if (aw_hs) begin
                    wr_next = W_DATA;
                end else if (w_hs) begin
                    wr_next = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) begin
                    wr_next     = W_WAIT;
                    wr_cnt_next = CNT_W'(WRITE_LATENCY);
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    wr_next     = W_WAIT;
                    wr_cnt_next = CNT_W'(WRITE_LATENCY);
                end
            end
            W_WAIT: begin
                if (wr_cnt == '0) begin
                    wr_next     = W_RESP;
                    wr_commit_c = 1'b1;
                end else begin
                    wr_cnt_next = wr_cnt - CNT_W'(1);
                end
            end
            W_RESP: begin
                if (b_hs) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state  <= W_IDLE;
            wr_cnt    <= '0;
            wr_idx_q  <= '0;
            wr_resp_q <= RESP_OKAY;
            wr_beat_q <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            wr_state  <= wr_next;
            wr_cnt    <= wr_cnt_next;
            awready_q <= (wr_next == W_IDLE) || (wr_next == W_ADDR);
            wready_q  <= (wr_next == W_IDLE) || (wr_next == W_DATA);
            bvalid_q  <= (wr_next == W_RESP);
            if (aw_hs) begin
                wr_idx_q  <= word_idx(mem_w.awaddr);
                wr_resp_q <= req_resp(mem_w.awaddr, mem_w.awlen);
                bid_q     <= mem_w.awid;
            end
            if (w_hs) wr_beat_q <= '{data: mem_w.wdata, strb: mem_w.wstrb};
            if (wr_commit_c) bresp_q <= wr_resp_q;
        end
    end

    ysyx_23060203_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_capture_c),
        .rd_hit  (rd_resp_c == RESP_OKAY),
        .rd_idx  (rd_idx_c),
        .rd_data (rd_data),
        .wr_en   (wr_commit_c && (wr_resp_q == RESP_OKAY)),
        .wr_idx  (wr_idx_q),
        .wr_data (wr_beat_q.data),
        .wr_strb (wr_beat_q.strb)
    );

    assign mem_r.arready = arready_q;
    assign mem_r.rvalid  = rvalid_q;
    assign mem_r.rlast   = rvalid_q;
    assign mem_r.rdata   = rd_data;
    assign mem_r.rresp   = rresp_q;
    assign mem_r.rid     = rid_q;

    assign mem_w.awready = awready_q;
    assign mem_w.wready  = wready_q;
    assign mem_w.bvalid  = bvalid_q;
    assign mem_w.bresp   = bresp_q;
    assign mem_w.bid     = bid_q;

    // Each bundle carries only one direction; the other half is tied off.
    assign mem_r.awready = 1'b0;
    assign mem_r.wready  = 1'b0;
    assign mem_r.bvalid  = 1'b0;
    assign mem_r.bresp   = RESP_OKAY;
    assign mem_r.bid     = '0;
    assign mem_w.arready = 1'b0;
    assign mem_w.rvalid  = 1'b0;
    assign mem_w.rlast   = 1'b0;
    assign mem_w.rdata   = '0;
    assign mem_w.rresp   = RESP_OKAY;
    assign mem_w.rid     = '0;

    logic unused_ok;
    assign unused_ok = ^{mem_r.arsize, mem_r.arburst, mem_w.awsize, mem_w.awburst, mem_w.wlast,
                         mem_r.awvalid, mem_r.awaddr, mem_r.awid, mem_r.awlen, mem_r.awsize,
                         mem_r.awburst, mem_r.wvalid, mem_r.wdata, mem_r.wstrb, mem_r.wlast,
                         mem_r.bready, mem_w.arvalid, mem_w.araddr, mem_w.arid, mem_w.arlen,
                         mem_w.arsize, mem_w.arburst, mem_w.rready};

endmodule

// File: tb/tb_ysyx_23060203_axi_sram.sv
// Scoreboard bench for the AXI SRAM responder: tasks push expected R/B beats, a monitor checks them.
module tb_ysyx_23060203_axi_sram;
    import ysyx_23060203_axi_pkg::*;

    localparam int unsigned RL    = 1;
    localparam int unsigned WL    = 1;
    localparam int          LIMIT = 50;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        bit          chk_data;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    rexp_t rexp_q[$];
    bexp_t bexp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    axi_if mem_r();
    axi_if mem_w();

    ysyx_23060203_axi_sram #(
        .BASE          (32'h8000_0000),
        .DEPTH         (1024),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mem_r (mem_r),
        .mem_w (mem_w)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted R or B beat is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && mem_r.rvalid && mem_r.rready) begin
                if (rexp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL r_spurious: got beat rdata %h with nothing expected", mem_r.rdata);
                end else begin
                    rexp_t e;
                    e = rexp_q.pop_front();
                    check("rid", 32'(mem_r.rid), 32'(e.id));
                    check("rresp", 32'(mem_r.rresp), 32'(e.resp));
                    check("rlast", 32'(mem_r.rlast), 32'd1);
                    if (e.chk_data) check("rdata", mem_r.rdata, e.data);
                end
            end
            if (reset && mem_w.bvalid && mem_w.bready) begin
                if (bexp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_spurious: got bid %h with nothing expected", mem_w.bid);
                end else begin
                    bexp_t e;
                    e = bexp_q.pop_front();
                    check("bid", 32'(mem_w.bid), 32'(e.id));
                    check("bresp", 32'(mem_w.bresp), 32'(e.resp));
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        mem_w.awaddr = addr; mem_w.awid = id; mem_w.awlen = len;
        mem_w.awsize = 3'd2; mem_w.awburst = 2'b01; mem_w.awvalid = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clock);
            if (mem_w.awready) break;
        end
        check("awready_seen", 32'(mem_w.awready), 32'd1);
        @(posedge clock); #1;
        mem_w.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        mem_w.wdata = data; mem_w.wstrb = strb; mem_w.wlast = 1'b1; mem_w.wvalid = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clock);
            if (mem_w.wready) break;
        end
        check("wready_seen", 32'(mem_w.wready), 32'd1);
        @(posedge clock); #1;
        mem_w.wvalid = 1'b0;
    endtask

    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id, input logic [7:0] len);
        mem_w.awaddr = addr; mem_w.awid = id; mem_w.awlen = len;
        mem_w.awsize = 3'd2; mem_w.awburst = 2'b01; mem_w.awvalid = 1'b1;
        mem_w.wdata = data; mem_w.wstrb = strb; mem_w.wlast = 1'b1; mem_w.wvalid = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clock);
            if (mem_w.awready && mem_w.wready) break;
        end
        check("aw_w_ready_seen", 32'(mem_w.awready && mem_w.wready), 32'd1);
        @(posedge clock); #1;
        mem_w.awvalid = 1'b0;
        mem_w.wvalid  = 1'b0;
    endtask

    // mode 0: AW+W together, 1: W then AW after gap, 2: AW then W after gap.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] exp_resp, input int mode, input int gap,
                             output int lat);
        bexp_q.push_back('{resp: exp_resp, id: id});
        if (mode == 0) begin
            send_aw_w(addr, data, strb, id, len);
        end else if (mode == 1) begin
            send_w(data, strb);
            repeat (gap) @(posedge clock);
            #1;
            send_aw(addr, id, len);
        end else begin
            send_aw(addr, id, len);
            repeat (gap) @(posedge clock);
            #1;
            send_w(data, strb);
        end
        lat = 0;
        while (lat < LIMIT) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (mem_w.bvalid) break;
        end
        check("bvalid_seen", 32'(mem_w.bvalid), 32'd1);
        if (mem_w.bvalid && mem_w.bready) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input bit chk_data, output int lat);
        rexp_q.push_back('{data: exp_data, resp: exp_resp, id: id, chk_data: chk_data});
        mem_r.araddr = addr; mem_r.arid = id; mem_r.arlen = len;
        mem_r.arsize = 3'd2; mem_r.arburst = 2'b01; mem_r.arvalid = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clock);
            if (mem_r.arready) break;
        end
        check("arready_seen", 32'(mem_r.arready), 32'd1);
        @(posedge clock); #1;
        mem_r.arvalid = 1'b0;
        lat = 0;
        while (lat < LIMIT) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (mem_r.rvalid) break;
        end
        check("rvalid_seen", 32'(mem_r.rvalid), 32'd1);
        if (mem_r.rvalid && mem_r.rready) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int lat_r, lat_w;
        mem_r.arvalid = 0; mem_r.araddr = 0; mem_r.arid = 0; mem_r.arlen = 0;
        mem_r.arsize = 0; mem_r.arburst = 0; mem_r.rready = 1;
        mem_r.awvalid = 0; mem_r.awaddr = 0; mem_r.awid = 0; mem_r.awlen = 0;
        mem_r.awsize = 0; mem_r.awburst = 0; mem_r.wvalid = 0; mem_r.wdata = 0;
        mem_r.wstrb = 0; mem_r.wlast = 0; mem_r.bready = 0;
        mem_w.arvalid = 0; mem_w.araddr = 0; mem_w.arid = 0; mem_w.arlen = 0;
        mem_w.arsize = 0; mem_w.arburst = 0; mem_w.rready = 0;
        mem_w.awvalid = 0; mem_w.awaddr = 0; mem_w.awid = 0; mem_w.awlen = 0;
        mem_w.awsize = 0; mem_w.awburst = 0; mem_w.wvalid = 0; mem_w.wdata = 0;
        mem_w.wstrb = 0; mem_w.wlast = 0; mem_w.bready = 1;

        // Outputs held low while reset is asserted.
        @(negedge clock);
        check("rst_arready", 32'(mem_r.arready), 32'd0);
        check("rst_awready", 32'(mem_w.awready), 32'd0);
        check("rst_wready", 32'(mem_w.wready), 32'd0);
        check("rst_rvalid", 32'(mem_r.rvalid), 32'd0);
        check("rst_bvalid", 32'(mem_w.bvalid), 32'd0);
        check("rst_rdata", mem_r.rdata, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("idle_arready", 32'(mem_r.arready), 32'd1);
        check("idle_awready", 32'(mem_w.awready), 32'd1);
        check("idle_wready", 32'(mem_w.wready), 32'd1);

        // Single write then read back with latency measurement.
        @(posedge clock); #1;
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'd1, 8'd0, RESP_OKAY, 0, 0, lat_w);
        check("w_latency", 32'(lat_w), 32'(1 + WL));
        axi_read(32'h8000_0010, 4'd2, 8'd0, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, lat_r);
        check("r_latency", 32'(lat_r), 32'(1 + RL));

        // Partial strobes.
        axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, 4'd3, 8'd0, RESP_OKAY, 0, 0, lat_w);
        axi_write(32'h8000_0020, 32'h0000_00AB, 4'h1, 4'd4, 8'd0, RESP_OKAY, 0, 0, lat_w);
        axi_read(32'h8000_0020, 4'd5, 8'd0, 32'h1122_33AB, RESP_OKAY, 1'b1, lat_r);
        axi_write(32'h8000_0020, 32'hCAFE_0000, 4'hC, 4'd6, 8'd0, RESP_OKAY, 0, 0, lat_w);
        axi_read(32'h8000_0020, 4'd7, 8'd0, 32'hCAFE_33AB, RESP_OKAY, 1'b1, lat_r);
        axi_write(32'h8000_0020, 32'h5555_5555, 4'h0, 4'd8, 8'd0, RESP_OKAY, 0, 0, lat_w);
        axi_read(32'h8000_0020, 4'd9, 8'd0, 32'hCAFE_33AB, RESP_OKAY, 1'b1, lat_r);

        // Separated channels: W leads AW, then AW leads W.
        axi_write(32'h8000_0030, 32'h55AA_55AA, 4'hF, 4'd5, 8'd0, RESP_OKAY, 1, 3, lat_w);
        check("w_first_latency", 32'(lat_w), 32'(1 + WL));
        axi_write(32'h8000_0034, 32'h0102_0304, 4'hF, 4'd6, 8'd0, RESP_OKAY, 2, 2, lat_w);
        check("aw_first_latency", 32'(lat_w), 32'(1 + WL));
        axi_read(32'h8000_0030, 4'd1, 8'd0, 32'h55AA_55AA, RESP_OKAY, 1'b1, lat_r);
        axi_read(32'h8000_0034, 4'd2, 8'd0, 32'h0102_0304, RESP_OKAY, 1'b1, lat_r);

        // Decode errors and burst rejection.
        axi_read(32'h7FFF_FFFC, 4'd3, 8'd0, 32'h0, RESP_DECERR, 1'b1, lat_r);
        axi_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 4'd4, 8'd0, RESP_OKAY, 0, 0, lat_w);
        axi_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 4'd5, 8'd0, RESP_DECERR, 0, 0, lat_w);
        axi_read(32'h8000_0000, 4'd6, 8'd0, 32'h0BAD_F00D, RESP_OKAY, 1'b1, lat_r);
        axi_read(32'h8000_0010, 4'd7, 8'd3, 32'h0, RESP_SLVERR, 1'b0, lat_r);
        axi_write(32'h8000_0000, 32'h1111_1111, 4'hF, 4'd8, 8'd2, RESP_SLVERR, 0, 0, lat_w);
        axi_read(32'h8000_0000, 4'd9, 8'd0, 32'h0BAD_F00D, RESP_OKAY, 1'b1, lat_r);

        // Backpressure: rdata held and arready low while rready is low.
        mem_r.rready = 1'b0;
        axi_read(32'h8000_0010, 4'hA, 8'd0, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, lat_r);
        for (int i = 0; i < 5; i++) begin
            check("bp_rdata", mem_r.rdata, 32'hDEAD_BEEF);
            check("bp_arready", 32'(mem_r.arready), 32'd0);
            check("bp_rvalid", 32'(mem_r.rvalid), 32'd1);
            @(negedge clock);
        end
        @(posedge clock); #1;
        mem_r.rready = 1'b1;
        @(posedge clock); #1;

        // Read capture and write commit to the same word in the same cycle.
        axi_write(32'h8000_0040, 32'h1234_5678, 4'hF, 4'hB, 8'd0, RESP_OKAY, 0, 0, lat_w);
        fork
            axi_read(32'h8000_0040, 4'hC, 8'd0, 32'h1234_5678, RESP_OKAY, 1'b1, lat_r);
            axi_write(32'h8000_0040, 32'h9ABC_DEF0, 4'hF, 4'hD, 8'd0, RESP_OKAY, 0, 0, lat_w);
        join
        check("coll_r_latency", 32'(lat_r), 32'(1 + RL));
        check("coll_w_latency", 32'(lat_w), 32'(1 + WL));
        axi_read(32'h8000_0040, 4'hE, 8'd0, 32'h9ABC_DEF0, RESP_OKAY, 1'b1, lat_r);

        // Reset asserted while a write waits to commit.
        axi_write(32'h8000_0050, 32'h7777_7777, 4'hF, 4'd1, 8'd0, RESP_OKAY, 0, 0, lat_w);
        send_aw_w(32'h8000_0050, 32'h8888_8888, 4'hF, 4'd2, 8'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_bvalid", 32'(mem_w.bvalid), 32'd0);
        check("mid_rst_arready", 32'(mem_r.arready), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("post_rst_awready", 32'(mem_w.awready), 32'd1);
        check("post_rst_wready", 32'(mem_w.wready), 32'd1);
        @(posedge clock); #1;
        axi_read(32'h8000_0050, 4'd3, 8'd0, 32'h7777_7777, RESP_OKAY, 1'b1, lat_r);

        repeat (3) @(posedge clock);
        check("r_queue_empty", 32'(rexp_q.size()), 32'd0);
        check("b_queue_empty", 32'(bexp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
